// File: rtl/arrow_if.sv
// Handshake-free bus between the game sequencer and its driver: pulse inputs in,
// registered lane coordinates and scoreboard out.
interface arrow_if;
    logic       start;
    logic       frame_tick;
    logic       key_pulse;
    logic [2:0] decode;
    logic [9:0] l_bottom, l_top;
    logic [9:0] r_bottom, r_top;
    logic [9:0] u_bottom, u_top;
    logic [9:0] d_bottom, d_top;
    logic [3:0] lane_active;
    logic [3:0] score;
    logic [3:0] miss_count;
    logic [3:0] hit_flash;
    logic       game_over;

    modport master (
        output start, frame_tick, key_pulse, decode,
        input  l_bottom, l_top, r_bottom, r_top, u_bottom, u_top, d_bottom, d_top,
        input  lane_active, score, miss_count, hit_flash, game_over
    );

    modport slave (
        input  start, frame_tick, key_pulse, decode,
        output l_bottom, l_top, r_bottom, r_top, u_bottom, u_top, d_bottom, d_top,
        output lane_active, score, miss_count, hit_flash, game_over
    );
endinterface

// File: rtl/arrow_scheduler.sv
// Four-lane arrow game sequencer: spawns, scrolls, judges hits and counts misses.
// Every output is registered and reflects a pulse on the following clock edge.
module arrow_scheduler #(
    parameter int unsigned VBP       = 31,
    parameter int unsigned VFP       = 511,
    parameter int unsigned ARROW_H   = 80,
    parameter int unsigned SPEED     = 2,
    parameter int unsigned HIT_LO    = 205,
    parameter int unsigned HIT_HI    = 290,
    parameter int unsigned SPAWN_GAP = 40,
    parameter int unsigned MAX_MISS  = 9,
    parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
    input  logic    clk_i,
    input  logic    rst_i,
    arrow_if.slave  arw
);
    localparam int unsigned GAP_W = $clog2(SPAWN_GAP);

    localparam logic [9:0]       SPAWN_BOT = 10'(VFP - ARROW_H);
    localparam logic [9:0]       SPAWN_TOP = 10'(VFP);
    localparam logic [9:0]       MOVE_MIN  = 10'(VBP + SPEED);
    localparam logic [9:0]       STEP      = 10'(SPEED);
    localparam logic [9:0]       WIN_LO    = 10'(HIT_LO);
    localparam logic [9:0]       WIN_HI    = 10'(HIT_HI);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(SPAWN_GAP - 1);
    localparam logic [4:0]       MISS_SAT  = 5'(MAX_MISS);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [3:0]         active_q, active_d;
    logic [9:0]         bottom_q [4];
    logic [9:0]         bottom_d [4];
    logic [9:0]         top_q [4];
    logic [9:0]         top_d [4];
    logic [3:0]         score_q, score_d;
    logic [3:0]         miss_q, miss_d;
    logic [3:0]         flash_q, flash_d;
    logic               over_q, over_d;

    logic [3:0]         hit_vec;
    logic [2:0]         miss_inc;
    logic [4:0]         miss_sum;
    logic [1:0]         key_lane;
    logic [1:0]         spawn_lane;

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        gap_d      = gap_q;
        active_d   = active_q;
        bottom_d   = bottom_q;
        top_d      = top_q;
        score_d    = score_q;
        miss_d     = miss_q;
        flash_d    = flash_q;
        hit_vec    = '0;
        miss_inc   = '0;
        miss_sum   = '0;
        key_lane   = arw.decode[1:0];
        spawn_lane = lfsr_q[1:0];

        case (state_q)
            IDLE: begin
                if (arw.start) begin
                    state_d  = RUN;
                    gap_d    = '0;
                    active_d = '0;
                    score_d  = '0;
                    miss_d   = '0;
                    flash_d  = '0;
                    for (int i = 0; i < 4; i++) begin
                        bottom_d[i] = '0;
                        top_d[i]    = '0;
                    end
                end
            end

            RUN: begin
                // Judge against the pre-move position so a same-cycle scroll cannot steal the hit.
                if (arw.key_pulse && !arw.decode[2] && active_q[key_lane] &&
                    bottom_q[key_lane] >= WIN_LO && bottom_q[key_lane] <= WIN_HI) begin
                    hit_vec[key_lane] = 1'b1;
                end

                if (arw.frame_tick) begin
                    flash_d = '0;
                    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                    gap_d   = (gap_q == GAP_LAST) ? '0 : gap_q + 1'b1;
                end

                for (int i = 0; i < 4; i++) begin
                    if (hit_vec[i]) begin
                        active_d[i] = 1'b0;
                        bottom_d[i] = '0;
                        top_d[i]    = '0;
                    end else if (arw.frame_tick && active_q[i]) begin
                        if (bottom_q[i] >= MOVE_MIN) begin
                            bottom_d[i] = bottom_q[i] - STEP;
                            top_d[i]    = top_q[i] - STEP;
                        end else begin
                            active_d[i] = 1'b0;
                            bottom_d[i] = '0;
                            top_d[i]    = '0;
                            miss_inc    = miss_inc + 3'd1;
                        end
                    end
                end

                if (arw.frame_tick && gap_q == GAP_LAST &&
                    !active_q[spawn_lane] && !hit_vec[spawn_lane]) begin
                    active_d[spawn_lane] = 1'b1;
                    bottom_d[spawn_lane] = SPAWN_BOT;
                    top_d[spawn_lane]    = SPAWN_TOP;
                end

                flash_d = flash_d | hit_vec;
                if (|hit_vec && score_q != 4'd9) begin
                    score_d = score_q + 4'd1;
                end

                miss_sum = {1'b0, miss_q} + {2'b00, miss_inc};
                if (miss_sum >= MISS_SAT) begin
                    miss_d  = MISS_SAT[3:0];
                    state_d = OVER;
                end else begin
                    miss_d = miss_sum[3:0];
                end
            end

            OVER: begin
                if (arw.start) begin
                    state_d  = IDLE;
                    gap_d    = '0;
                    active_d = '0;
                    score_d  = '0;
                    miss_d   = '0;
                    flash_d  = '0;
                    for (int i = 0; i < 4; i++) begin
                        bottom_d[i] = '0;
                        top_d[i]    = '0;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        over_d = (state_d == OVER);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            lfsr_q   <= LFSR_SEED;
            gap_q    <= '0;
            active_q <= '0;
            score_q  <= '0;
            miss_q   <= '0;
            flash_q  <= '0;
            over_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                bottom_q[i] <= '0;
                top_q[i]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            gap_q    <= gap_d;
            active_q <= active_d;
            score_q  <= score_d;
            miss_q   <= miss_d;
            flash_q  <= flash_d;
            over_q   <= over_d;
            for (int i = 0; i < 4; i++) begin
                bottom_q[i] <= bottom_d[i];
                top_q[i]    <= top_d[i];
            end
        end
    end

    assign arw.l_bottom    = bottom_q[0];
    assign arw.l_top       = top_q[0];
    assign arw.r_bottom    = bottom_q[1];
    assign arw.r_top       = top_q[1];
    assign arw.u_bottom    = bottom_q[2];
    assign arw.u_top       = top_q[2];
    assign arw.d_bottom    = bottom_q[3];
    assign arw.d_top       = top_q[3];
    assign arw.lane_active = active_q;
    assign arw.score       = score_q;
    assign arw.miss_count  = miss_q;
    assign arw.hit_flash   = flash_q;
    assign arw.game_over   = over_q;
endmodule

// File: tb/tb_arrow_scheduler.sv
// Directed bench for arrow_scheduler; lane choices follow the seed-A5 LFSR sequence
// (first spawns: tick 40 right, tick 80 right again (skipped), tick 120 left).
module tb_arrow_scheduler;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    arrow_if arw ();

    arrow_scheduler dut (
        .clk_i (clk),
        .rst_i (rst),
        .arw   (arw)
    );

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        arw.frame_tick = 1'b1;
        @(negedge clk);
        arw.frame_tick = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic [2:0] code, input logic with_tick);
        arw.key_pulse  = 1'b1;
        arw.decode     = code;
        arw.frame_tick = with_tick;
        @(negedge clk);
        arw.key_pulse  = 1'b0;
        arw.frame_tick = 1'b0;
        arw.decode     = 3'b111;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        arw.start = 1'b1;
        @(negedge clk);
        arw.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_coords"}, {arw.l_bottom, arw.l_top, arw.r_bottom, arw.r_top,
                                 arw.u_bottom, arw.u_top, arw.d_bottom, arw.d_top}, 80'd0);
        check({tag, "_active"}, 80'(arw.lane_active), 80'd0);
        check({tag, "_score"},  80'(arw.score), 80'd0);
        check({tag, "_miss"},   80'(arw.miss_count), 80'd0);
        check({tag, "_flash"},  80'(arw.hit_flash), 80'd0);
        check({tag, "_over"},   80'(arw.game_over), 80'd0);
    endtask

    initial begin
        int guard;
        rst            = 1'b1;
        arw.start      = 1'b0;
        arw.frame_tick = 1'b0;
        arw.key_pulse  = 1'b0;
        arw.decode     = 3'b111;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_idle("reset");

        // Ticks in IDLE must neither spawn nor advance the gap counter or LFSR.
        ticks(5);
        check("idle_tick_active", 80'(arw.lane_active), 80'd0);
        pulse_start();
        check("run_over", 80'(arw.game_over), 80'd0);

        ticks(39);
        check("pre_spawn_active", 80'(arw.lane_active), 80'd0);
        tick();
        check("spawn_active", 80'(arw.lane_active), 80'b0010);
        check("spawn_r_bottom", 80'(arw.r_bottom), 80'd431);
        check("spawn_r_top", 80'(arw.r_top), 80'd511);
        check("spawn_score", 80'(arw.score), 80'd0);

        ticks(65);
        check("t105_r_bottom", 80'(arw.r_bottom), 80'd301);
        press(3'b001, 1'b0);
        check("early_r_bottom", 80'(arw.r_bottom), 80'd301);
        check("early_r_active", 80'(arw.lane_active[1]), 80'd1);
        check("early_score", 80'(arw.score), 80'd0);

        ticks(5);
        press(3'b001, 1'b0);
        check("win_hi_edge_bottom", 80'(arw.r_bottom), 80'd291);
        check("win_hi_edge_score", 80'(arw.score), 80'd0);

        ticks(15);
        press(3'b101, 1'b0);
        check("none_code_active", 80'(arw.lane_active[1]), 80'd1);
        check("none_code_score", 80'(arw.score), 80'd0);
        press(3'b010, 1'b0);
        check("wrong_lane_score", 80'(arw.score), 80'd0);

        ticks(5);
        check("t130_r_bottom", 80'(arw.r_bottom), 80'd251);
        press(3'b001, 1'b0);
        check("hit_r_active", 80'(arw.lane_active[1]), 80'd0);
        check("hit_r_coords", 80'({arw.r_bottom, arw.r_top}), 80'd0);
        check("hit_score", 80'(arw.score), 80'd1);
        check("hit_flash", 80'(arw.hit_flash), 80'b0010);
        tick();
        check("flash_clear", 80'(arw.hit_flash), 80'd0);

        ticks(102);
        check("t233_l_bottom", 80'(arw.l_bottom), 80'd205);
        check("t233_l_top", 80'(arw.l_top), 80'd285);
        press(3'b000, 1'b1);
        check("simul_l_coords", 80'({arw.l_bottom, arw.l_top}), 80'd0);
        check("simul_l_active", 80'(arw.lane_active[0]), 80'd0);
        check("simul_score", 80'(arw.score), 80'd2);
        check("simul_flash", 80'(arw.hit_flash), 80'b0001);
        check("simul_miss", 80'(arw.miss_count), 80'd0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("midrst");

        pulse_start();
        ticks(240);
        check("t240_r_bottom", 80'(arw.r_bottom), 80'd31);
        check("t240_r_top", 80'(arw.r_top), 80'd111);
        check("t240_miss", 80'(arw.miss_count), 80'd0);
        tick();
        check("retire_r_active", 80'(arw.lane_active[1]), 80'd0);
        check("retire_r_coords", 80'({arw.r_bottom, arw.r_top}), 80'd0);
        check("retire_miss", 80'(arw.miss_count), 80'd1);

        guard = 0;
        while (arw.miss_count != 4'd9 && guard < 3000) begin
            tick();
            guard++;
        end
        check("miss_reach9", 80'(arw.miss_count), 80'd9);
        check("over_at_9", 80'(arw.game_over), 80'd1);
        check("over_score", 80'(arw.score), 80'd0);

        for (int k = 0; k < 4; k++) press(3'(k), 1'b1);
        ticks(3);
        check("frozen_miss", 80'(arw.miss_count), 80'd9);
        check("frozen_score", 80'(arw.score), 80'd0);
        check("frozen_over", 80'(arw.game_over), 80'd1);
        check("frozen_flash", 80'(arw.hit_flash), 80'd0);

        pulse_start();
        check_idle("over_to_idle");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
